// File: rtl/mem_copy_engine.sv
// Block-copy bus master: copies `count` words from src_addr to dst_addr,
// spending one read cycle and one write cycle on each word.
module mem_copy_engine #(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH-1:0] count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_data,
    input  logic [WORD_SIZE-1:0]  mem_in,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic                  mem_en
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_src_ptr;
    logic [ADDR_WIDTH-1:0] r_dst_ptr;
    logic [ADDR_WIDTH-1:0] r_remaining;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [WORD_SIZE-1:0]  r_buf;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_mem_rd;
    logic                  r_mem_wr;
    logic                  r_mem_en;
    logic [ADDR_WIDTH-1:0] w_src_next;
    logic [ADDR_WIDTH-1:0] w_dst_next;

    assign w_src_next = r_src_ptr + ADDR_WIDTH'(1);
    assign w_dst_next = r_dst_ptr + ADDR_WIDTH'(1);

    // Outputs are registered with the state they belong to; r_buf doubles
    // as the write-data register and is zero outside WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
            r_mem_addr  <= '0;
            r_buf       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_en    <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
            r_buf      <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_src_ptr   <= src_addr;
                            r_dst_ptr   <= dst_addr;
                            r_remaining <= count;
                            r_state     <= S_READ;
                            r_mem_en    <= 1'b1;
                            r_mem_rd    <= 1'b1;
                            r_mem_addr  <= src_addr;
                        end
                    end
                end
                S_READ: begin
                    r_buf      <= mem_in;
                    r_state    <= S_WRITE;
                    r_mem_en   <= 1'b1;
                    r_mem_wr   <= 1'b1;
                    r_mem_addr <= r_dst_ptr;
                end
                S_WRITE: begin
                    r_src_ptr   <= w_src_next;
                    r_dst_ptr   <= w_dst_next;
                    r_remaining <= r_remaining - ADDR_WIDTH'(1);
                    if (r_remaining == ADDR_WIDTH'(1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= S_READ;
                        r_mem_en   <= 1'b1;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= w_src_next;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_buf;
    assign mem_rd   = r_mem_rd;
    assign mem_wr   = r_mem_wr;
    assign mem_en   = r_mem_en;
endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Bus-master block-copy engine for the simulation memory bus. It drives address, enable, read and write strobes on the single-port memory interface, where read data returns combinationally and writes commit on the rising clock edge. On a start command it copies `count` consecutive words from a source address to a destination address, one read cycle and one write cycle per word, then pulses `done`. It sits between the control logic and any memory on that bus, and is used for boot-time ROM-to-RAM loading and bulk moves.

## Interface
- `WORD_SIZE`, 32, data word width.
- `ADDR_WIDTH`, 16, address width; the address space wraps modulo 2^ADDR_WIDTH.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `src_addr`  in  ADDR_WIDTH  first source word address; latched on an accepted start.
- `dst_addr`  in  ADDR_WIDTH  first destination word address; latched on an accepted start.
- `count`  in  ADDR_WIDTH  number of words to copy; latched on an accepted start; 0 is legal.
- `busy`  out  1  high in READ, WRITE and DONE.
- `done`  out  1  one-cycle completion pulse.
- `mem_addr`  out  ADDR_WIDTH  bus address.
- `mem_data`  out  WORD_SIZE  bus write data.
- `mem_in`  in  WORD_SIZE  bus read data; valid combinationally while `mem_en && mem_rd`.
- `mem_rd`, `mem_wr`, `mem_en`  out  1 each  bus strobes.

## Operation
- FSM states: IDLE, READ, WRITE, DONE. Registers: `src_ptr`, `dst_ptr`, `remaining`, `buf`.
- IDLE:
  - All strobes are 0, `mem_addr` = 0, `mem_data` = 0.
  - `start` with `count` == 0 → DONE. No bus activity.
  - `start` with `count` != 0 → latch the pointers and `remaining` = `count`, then → READ.
- READ:
  - Drives `mem_en` = 1, `mem_rd` = 1, `mem_wr` = 0, `mem_addr` = `src_ptr`.
  - At the edge: `buf` ← `mem_in`, → WRITE.
- WRITE:
  - Drives `mem_en` = 1, `mem_wr` = 1, `mem_rd` = 0, `mem_addr` = `dst_ptr`, `mem_data` = `buf`.
  - At the edge: `src_ptr`++, `dst_ptr`++, `remaining`--.
  - If `remaining` was 1 → DONE, else → READ.
- DONE: `done` = 1, all strobes 0, → IDLE unconditionally.
- `start` is ignored in READ, WRITE and DONE. No command is queued.
- Pointer increments wrap: 0xFFFF + 1 = 0x0000 for ADDR_WIDTH = 16.
- Copy order is ascending. Overlapping regions with `dst` > `src` propagate already-copied data; this behaviour is defined and is not corrected.
- `mem_rd` and `mem_wr` are never high in the same cycle. `mem_en` is high exactly when one of them is high.

## Timing
- Every output is a registered state decode, so outputs change only after a rising edge.
- Reset values: state IDLE, `busy` = 0, `done` = 0, `mem_en`/`mem_rd`/`mem_wr` = 0, `mem_addr` = 0, `mem_data` = 0. Internal registers clear to 0.
- Counting cycles from the edge that samples `start` (edge 0):
  - Word i (0-based) is read in cycle 2i+1 and written in cycle 2i+2. The write commits at the edge that ends cycle 2i+2.
  - `done` is high in cycle 2N+1.
  - `busy` is high in cycles 1 through 2N+1.
  - A new start is accepted no earlier than edge 2N+2.
- `count` = 0: `done` and `busy` are high in cycle 1 only.
- Throughput: 2 cycles per word.
- `rst` mid-operation: at the next edge, return to IDLE with all strobes low. Words already written remain in memory. No `done` pulse is produced.
- `rst` and `start` asserted together: reset wins.

## Test plan
- Preload memory at 0x0010..0x0013 = A0, A1, A2, A3. Start with src = 0x0010, dst = 0x0100, count = 4 → memory at 0x0100..0x0103 holds A0..A3. Bus shows alternating rd/wr at 0x0010/0x0100, 0x0011/0x0101, … `done` pulses in cycle 9. `busy` is high in cycles 1–9.
- Start with count = 0 → `done` = 1 in cycle 1. No `mem_en` in any cycle. Back in IDLE in cycle 2.
- Start with src = 0xFFFE, dst = 0x0200, count = 4 → reads occur at 0xFFFE, 0xFFFF, 0x0000, 0x0001. Writes occur at 0x0200..0x0203.
- During a count = 3 copy, pulse `start` in cycles 2 and 7 with different addresses → both pulses are ignored. Only the original copy executes, and exactly one `done` pulse occurs, in cycle 7.
- During a count = 8 copy, assert `rst` in cycle 5 → strobes go low from cycle 6. Destination words 0–1 are written and word 2 is not. `done` never pulses. A fresh start afterwards completes normally.
- Overlapping copy: src = 0x0000, dst = 0x0001, count = 3, with mem[0] = X → mem[1..3] all equal X.
